// File: rtl/input_buffer_fifo.sv
// Router input-port FIFO with occupancy tracking, almost-full threshold,
// arbitrary depth, synchronous flush and sticky overflow/underflow flags.
module input_buffer_fifo #(
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 5,
    parameter  int AF_THRESH  = DEPTH - 1,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  buf_flush_i,
    input  logic                  buf_write_i,
    input  logic [DATA_WIDTH-1:0] buf_data_i,
    input  logic                  buf_read_i,
    output logic [DATA_WIDTH-1:0] buf_data_o,
    output logic                  buf_valid_o,
    output logic                  buf_empty_o,
    output logic                  buf_full_o,
    output logic                  buf_almost_full_o,
    output logic [CNT_WIDTH-1:0]  buf_count_o,
    output logic                  buf_overflow_o,
    output logic                  buf_underflow_o,
    output logic [ADDR_WIDTH-1:0] buf_ram_waddr_o,
    output logic [ADDR_WIDTH-1:0] buf_ram_raddr_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [CNT_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  empty;
    logic                  full;
    logic                  wr_ok;
    logic                  rd_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(
        input logic [ADDR_WIDTH-1:0] p
    );
        return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_WIDTH'(DEPTH));

    // Accept decisions; a pop frees a slot for a same-cycle push at full
    always_comb begin
        rd_ok = buf_read_i && !empty;
        wr_ok = buf_write_i && (!full || rd_ok);
    end

    // Storage array; not cleared by reset or flush
    always_ff @(posedge clk) begin
        if (wr_ok && !buf_flush_i) begin
            mem[waddr] <= buf_data_i;
        end
    end

    // Pointers, occupancy, read register and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waddr   <= '0;
            raddr   <= '0;
            count   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else if (buf_flush_i) begin
            waddr   <= '0;
            raddr   <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            valid_q <= rd_ok;
            if (rd_ok) begin
                data_q <= mem[raddr];
                raddr  <= next_ptr(raddr);
            end
            if (wr_ok) begin
                waddr <= next_ptr(waddr);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
            if (buf_write_i && !wr_ok) begin
                ovf_q <= 1'b1;
            end
            if (buf_read_i && !rd_ok) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign buf_data_o        = data_q;
    assign buf_valid_o       = valid_q;
    assign buf_empty_o       = empty;
    assign buf_full_o        = full;
    assign buf_almost_full_o = (count >= CNT_WIDTH'(AF_THRESH));
    assign buf_count_o       = count;
    assign buf_overflow_o    = ovf_q;
    assign buf_underflow_o   = udf_q;
    assign buf_ram_waddr_o   = waddr;
    assign buf_ram_raddr_o   = raddr;

endmodule

// File: tb/tb_input_buffer_fifo.sv
// Self-checking bench for input_buffer_fifo: directed scenarios then
// random traffic, checked against a queue-based model and a scoreboard.
module tb_input_buffer_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 5;
    localparam int AF    = DEPTH - 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          wr;
    logic [DW-1:0] din;
    logic          rd;
    logic [DW-1:0] dout;
    logic          valid;
    logic          empty;
    logic          full;
    logic          afull;
    logic [CW-1:0] count;
    logic          ovf;
    logic          udf;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    input_buffer_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .AF_THRESH(AF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .buf_flush_i(flush),
        .buf_write_i(wr),
        .buf_data_i(din),
        .buf_read_i(rd),
        .buf_data_o(dout),
        .buf_valid_o(valid),
        .buf_empty_o(empty),
        .buf_full_o(full),
        .buf_almost_full_o(afull),
        .buf_count_o(count),
        .buf_overflow_o(ovf),
        .buf_underflow_o(udf),
        .buf_ram_waddr_o(waddr),
        .buf_ram_raddr_o(raddr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: contents as a queue, plus flags and pop totals
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] m_last;
    bit            m_ovf;
    bit            m_udf;
    bit            m_valid;
    int            m_wn;
    int            m_rn;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        sb.delete();
        m_last  = '0;
        m_ovf   = 0;
        m_udf   = 0;
        m_valid = 0;
        m_wn    = 0;
        m_rn    = 0;
    endtask

    task automatic check_status();
        int n;
        n = m_q.size();
        chk("count", int'(count), n);
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == DEPTH));
        chk("afull", int'(afull), int'(n >= AF));
        chk("ovf", int'(ovf), int'(m_ovf));
        chk("udf", int'(udf), int'(m_udf));
        chk("valid", int'(valid), int'(m_valid));
        chk("waddr", int'(waddr), m_wn % DEPTH);
        chk("raddr", int'(raddr), m_rn % DEPTH);
        if (!m_valid) chk("hold", int'(dout), int'(m_last));
    endtask

    // Called at a falling edge: check state, drive one cycle, advance model
    task automatic step(input bit f, input bit w, input logic [DW-1:0] d,
                        input bit r);
        bit rok;
        bit wok;
        check_status();
        flush = f;
        wr    = w;
        din   = d;
        rd    = r;
        rok = r && (m_q.size() > 0);
        wok = w && ((m_q.size() < DEPTH) || rok);
        if (f) begin
            m_q.delete();
            m_ovf   = 0;
            m_udf   = 0;
            m_valid = 0;
            m_wn    = 0;
            m_rn    = 0;
        end else begin
            m_valid = rok;
            if (rok) begin
                m_last = m_q.pop_front();
                sb.push_back(m_last);
                m_rn++;
            end else if (r) begin
                m_udf = 1;
            end
            if (wok) begin
                m_q.push_back(d);
                m_wn++;
            end else if (w) begin
                m_ovf = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every popped word must match the next scoreboard entry
    always @(negedge clk) begin
        if (!reset && valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL rdata: got %0h with no read expected", dout);
            end else if (dout !== sb[0]) begin
                fails++;
                $display("FAIL rdata: got %0h expected %0h", dout, sb[0]);
                void'(sb.pop_front());
            end else begin
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        wr    = 1'b0;
        din   = '0;
        rd    = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_data", int'(dout), 0);
        reset = 1'b0;

        for (int i = 1; i <= 6; i++) step(0, 1, DW'(i), 0);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1);
        step(1, 0, '0, 0);

        for (int i = 0; i < 3; i++) step(0, 1, DW'(16'h00A0 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
        for (int i = 3; i < 7; i++) step(0, 1, DW'(16'h00A0 + i), 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

        for (int i = 0; i < 5; i++) step(0, 1, DW'(16'h0B00 + i), 0);
        step(0, 1, 16'h0BEE, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 1, 16'h0BEF, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 1, 16'h0C00, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        for (int i = 0; i < 6; i++) step(0, 1, DW'(16'h0D00 + i), 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(1, 1, 16'hDEAD, 0);
        step(0, 0, '0, 0);

        for (int i = 0; i < 4; i++) step(0, 1, DW'(16'h0E00 + i), 0);
        check_status();
        wr  = 1'b1;
        din = 16'h0E04;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_status();
        chk("arst_data", int'(dout), 0);
        wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 16'h1234, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        for (int blk = 0; blk < 30; blk++) begin
            int wp;
            int rp;
            wp = $urandom_range(15, 85);
            rp = $urandom_range(15, 85);
            for (int i = 0; i < 80; i++) begin
                step(($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 99) < wp),
                     DW'($urandom),
                     ($urandom_range(0, 99) < rp));
            end
        end

        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_buffer_fifo.md
# input_buffer_fifo

Parametrised input FIFO for the router input port. It replaces the fixed-size input buffer, which had a hard-wired empty flag and free-running pointers. The block adds true full/empty tracking, an occupancy count, an almost-full threshold, non-power-of-two depth with explicit pointer wrap, a synchronous flush, and sticky overflow/underflow error flags. It sits between the link receiver (write side) and the port arbiter (read side).

## Interface
Parameters:
- DATA_WIDTH, 16, flit width in bits
- DEPTH, 5, number of entries; any value ≥ 2, power of two not required
- AF_THRESH, DEPTH-1, buf_almost_full_o asserts when count ≥ AF_THRESH; legal range 1..DEPTH
- Derived (localparam): ADDR_WIDTH = $clog2(DEPTH), CNT_WIDTH = $clog2(DEPTH+1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- buf_flush_i  in  1  synchronous clear of contents and error flags
- buf_write_i  in  1  write request
- buf_data_i  in  DATA_WIDTH  write data
- buf_read_i  in  1  read request
- buf_data_o  out  DATA_WIDTH  registered read data
- buf_valid_o  out  1  buf_data_o carries a newly popped entry this cycle
- buf_empty_o  out  1  count == 0
- buf_full_o  out  1  count == DEPTH
- buf_almost_full_o  out  1  count ≥ AF_THRESH
- buf_count_o  out  CNT_WIDTH  current occupancy
- buf_overflow_o  out  1  sticky: a write was rejected
- buf_underflow_o  out  1  sticky: a read was rejected
- buf_ram_waddr_o / buf_ram_raddr_o  out  ADDR_WIDTH  current write/read pointers (debug)

## Operation
- Storage: DEPTH × DATA_WIDTH register array, with a write pointer, a read pointer and a count register.
- Accepted write (wr_ok): buf_write_i and (!full or rd_ok). The array entry at waddr is written; waddr advances.
- Accepted read (rd_ok): buf_read_i and !empty. The entry at raddr is registered into buf_data_o; raddr advances.
- Empty-bypass is not supported: a write and read in the same cycle while empty gives a write accept and a read reject.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. The count never exceeds DEPTH.
- Count update: +1 on wr_ok only, −1 on rd_ok only, unchanged when both or neither occur.
- Rejected write (buf_write_i while full, no rd_ok): the data is dropped and buf_overflow_o sets.
- Rejected read (buf_read_i while empty): buf_underflow_o sets and buf_valid_o stays 0.
- Sticky flags clear only on reset or flush.
- Flush has priority over read and write in the same cycle:
  - pointers and count go to 0;
  - both error flags clear;
  - buf_valid_o is 0 on the next cycle;
  - buf_data_o holds its value;
  - array contents are not cleared.
- buf_data_o holds its last value when buf_valid_o = 0.

## Timing
- Reset (asynchronous assert) sets:
  - pointers = 0, count = 0;
  - buf_empty_o = 1;
  - buf_full_o, buf_almost_full_o, buf_valid_o, buf_overflow_o, buf_underflow_o = 0;
  - buf_data_o = 0.
- Reset released mid-operation: the first edge after deassert is a normal cycle. All prior contents are lost.
- Read latency: 1 cycle. An accepted read in cycle N gives buf_valid_o = 1 with the data in cycle N+1.
- Write-to-read latency: a write at edge N makes buf_empty_o fall after edge N. The earliest accepted read is cycle N+1, with data in N+2.
- Status outputs (empty, full, almost_full, count) are registered. They reflect the state after the last edge. They are not combinational functions of the current-cycle requests.
- Error flags assert the cycle after the offending request.
- Full with simultaneous read and write: both are accepted, count stays DEPTH, buf_full_o stays 1, no overflow.

## Test plan
- Reset, then write 0x0001..0x0005 on 5 consecutive cycles (DEPTH=5) -> count 5, buf_full_o = 1, buf_almost_full_o asserted from count 4; a 6th write (0x0006) sets buf_overflow_o and count stays 5.
- From full, read 5 consecutive cycles -> buf_valid_o high for 5 cycles carrying 0x0001..0x0005 in order; then buf_empty_o = 1; a further read sets buf_underflow_o with buf_valid_o = 0.
- Wrap: write 3, read 3, write 4, read 4 (values 0x00A0..0x00A6) -> data returned in order, waddr/raddr wrap 4→0, count ends 0.
- Simultaneous read+write at full and at count 2 -> count unchanged, no error flags, FIFO order preserved. At empty: write accepted, read rejected, underflow set.
- Flush with count 3 and overflow set, plus a same-cycle write -> next cycle count 0, empty 1, overflow 0, write ignored.
- Assert reset asynchronously mid-burst (between edges) with count 4 -> outputs go to reset values immediately. After release, write 0x1234 then read -> 0x1234 returned with valid.
